// File: rtl/ahbl_excl_monitor_pkg.sv
// Shared definitions for the AHB-Lite exclusive-access monitor:
// HTRANS encodings and the reservation tag width helper.
package ahbl_excl_monitor_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   function automatic int tag_width(input int w_addr, input int granule_log2);
      return w_addr - granule_log2;
   endfunction

endpackage

// File: rtl/ahbl_excl_monitor_excl_res_table.sv
// Per-master reservation slots with a parallel tag compare.
// A set on a slot takes priority over a clear of that slot in the same cycle.
module excl_res_table
   import ahbl_excl_monitor_pkg::*;
#(
   parameter int N_MASTERS = 4,
   parameter int W_TAG     = 30,
   parameter int W_IDX     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [W_TAG-1:0]     i_tag,
   output logic [N_MASTERS-1:0] o_hit,
   input  logic [N_MASTERS-1:0] i_clr,
   input  logic                 i_set,
   input  logic [W_IDX-1:0]     i_set_idx
);

   logic [N_MASTERS-1:0] r_valid;
   logic [W_TAG-1:0]     r_tag [N_MASTERS];

   for (genvar k = 0; k < N_MASTERS; k++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_valid[k] <= 1'b0;
            r_tag[k]   <= '0;
         end else if (i_set && (i_set_idx == W_IDX'(k))) begin
            r_valid[k] <= 1'b1;
            r_tag[k]   <= i_tag;
         end else if (i_clr[k]) begin
            r_valid[k] <= 1'b0;
         end
      end

      assign o_hit[k] = r_valid[k] && (r_tag[k] == i_tag);
   end

endmodule

// File: rtl/ahbl_excl_monitor.sv
// AHB-Lite global exclusive monitor: forwards transfers to a shared slave, flags
// hexokay, and turns failing exclusive writes into a one-cycle local OKAY.
module ahbl_excl_monitor
   import ahbl_excl_monitor_pkg::*;
#(
   parameter int N_MASTERS    = 4,
   parameter int W_ADDR       = 32,
   parameter int W_DATA       = 32,
   parameter int GRANULE_LOG2 = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              src_hready,
   output logic              src_hready_resp,
   output logic              src_hresp,
   output logic              src_hexokay,
   input  logic [W_ADDR-1:0] src_haddr,
   input  logic              src_hwrite,
   input  logic [1:0]        src_htrans,
   input  logic [2:0]        src_hsize,
   input  logic              src_hexcl,
   input  logic [7:0]        src_hmaster,
   input  logic [W_DATA-1:0] src_hwdata,
   output logic [W_DATA-1:0] src_hrdata,
   output logic              dst_hready,
   input  logic              dst_hready_resp,
   input  logic              dst_hresp,
   output logic [W_ADDR-1:0] dst_haddr,
   output logic              dst_hwrite,
   output logic [1:0]        dst_htrans,
   output logic [2:0]        dst_hsize,
   output logic [W_DATA-1:0] dst_hwdata,
   input  logic [W_DATA-1:0] dst_hrdata
);

   localparam int W_TAG = tag_width(W_ADDR, GRANULE_LOG2);
   localparam int W_IDX = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   logic                 w_aph, w_mapped, w_hit_m;
   logic                 w_xrd, w_xwr, w_pass, w_fail, w_set, w_wr_clr, w_err_clr;
   logic [W_IDX-1:0]     w_idx;
   logic [W_TAG-1:0]     w_tag;
   logic [N_MASTERS-1:0] w_hit, w_clr;

   logic                 r_dp_excl, r_dp_okay, r_dp_local, r_dp_read;
   logic [W_IDX-1:0]     r_dp_m;

   assign w_aph    = src_htrans[1] & src_hready;
   assign w_mapped = {24'd0, src_hmaster} < 32'(N_MASTERS);
   assign w_idx    = src_hmaster[W_IDX-1:0];
   assign w_tag    = src_haddr[W_ADDR-1:GRANULE_LOG2];
   assign w_hit_m  = w_hit[w_idx];

   assign w_xrd    = w_aph & src_hexcl & ~src_hwrite;
   assign w_xwr    = w_aph & src_hexcl & src_hwrite;
   assign w_pass   = w_xwr & w_mapped & w_hit_m;
   assign w_fail   = w_xwr & ~w_pass;
   assign w_set    = w_xrd & w_mapped;
   assign w_wr_clr = (w_aph & src_hwrite & ~src_hexcl) | w_pass;

   // An exclusive read that completes with an error loses its reservation.
   assign w_err_clr = r_dp_excl & r_dp_read & r_dp_okay & ~r_dp_local
                    & dst_hready_resp & dst_hresp;

   always_comb begin
      w_clr = w_wr_clr ? w_hit : '0;
      if (w_err_clr) w_clr[r_dp_m] = 1'b1;
   end

   excl_res_table #(
      .N_MASTERS (N_MASTERS),
      .W_TAG     (W_TAG),
      .W_IDX     (W_IDX)
   ) u_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_tag     (w_tag),
      .o_hit     (w_hit),
      .i_clr     (w_clr),
      .i_set     (w_set),
      .i_set_idx (w_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dp_excl  <= 1'b0;
         r_dp_okay  <= 1'b0;
         r_dp_local <= 1'b0;
         r_dp_read  <= 1'b0;
         r_dp_m     <= '0;
      end else if (src_hready) begin
         r_dp_excl  <= w_aph & src_hexcl;
         r_dp_okay  <= w_set | w_pass;
         r_dp_local <= w_fail;
         r_dp_read  <= w_aph & ~src_hwrite;
         r_dp_m     <= w_aph ? w_idx : '0;
      end
   end

   assign src_hready_resp = r_dp_local ? 1'b1 : dst_hready_resp;
   assign src_hresp       = r_dp_local ? 1'b0 : dst_hresp;
   assign src_hexokay     = r_dp_excl & r_dp_okay & ~r_dp_local;
   assign src_hrdata      = dst_hrdata;

   assign dst_hready = src_hready;
   assign dst_haddr  = src_haddr;
   assign dst_hwrite = src_hwrite;
   assign dst_hsize  = src_hsize;
   assign dst_hwdata = src_hwdata;
   assign dst_htrans = w_fail ? HTRANS_IDLE : src_htrans;

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Directed bench for ahbl_excl_monitor; upstream HREADY is looped back from
// HREADYOUT as on a single-slave bus.
module tb_ahbl_excl_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        src_hready, src_hready_resp, src_hresp, src_hexokay;
   logic [31:0] src_haddr;
   logic        src_hwrite;
   logic [1:0]  src_htrans;
   logic [2:0]  src_hsize;
   logic        src_hexcl;
   logic [7:0]  src_hmaster;
   logic [31:0] src_hwdata, src_hrdata;
   logic        dst_hready, dst_hready_resp, dst_hresp;
   logic [31:0] dst_haddr;
   logic        dst_hwrite;
   logic [1:0]  dst_htrans;
   logic [2:0]  dst_hsize;
   logic [31:0] dst_hwdata, dst_hrdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;
   assign src_hready = src_hready_resp;

   ahbl_excl_monitor dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .src_hready      (src_hready),
      .src_hready_resp (src_hready_resp),
      .src_hresp       (src_hresp),
      .src_hexokay     (src_hexokay),
      .src_haddr       (src_haddr),
      .src_hwrite      (src_hwrite),
      .src_htrans      (src_htrans),
      .src_hsize       (src_hsize),
      .src_hexcl       (src_hexcl),
      .src_hmaster     (src_hmaster),
      .src_hwdata      (src_hwdata),
      .src_hrdata      (src_hrdata),
      .dst_hready      (dst_hready),
      .dst_hready_resp (dst_hready_resp),
      .dst_hresp       (dst_hresp),
      .dst_haddr       (dst_haddr),
      .dst_hwrite      (dst_hwrite),
      .dst_htrans      (dst_htrans),
      .dst_hsize       (dst_hsize),
      .dst_hwdata      (dst_hwdata),
      .dst_hrdata      (dst_hrdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] m, input logic [31:0] addr,
                        input logic wr, input logic excl);
      src_hmaster = m;
      src_haddr   = addr;
      src_hwrite  = wr;
      src_hexcl   = excl;
      src_htrans  = 2'b10;
      src_hwdata  = addr ^ 32'hA5A5_0000;
      #1;
   endtask

   task automatic idle();
      src_htrans = 2'b00;
      src_hexcl  = 1'b0;
      src_hwrite = 1'b0;
      #1;
   endtask

   initial begin
      rst_n           = 1'b0;
      src_haddr       = '0;
      src_hwrite      = 1'b0;
      src_htrans      = 2'b00;
      src_hsize       = 3'b010;
      src_hexcl       = 1'b0;
      src_hmaster     = '0;
      src_hwdata      = '0;
      dst_hready_resp = 1'b0;
      dst_hresp       = 1'b1;
      dst_hrdata      = 32'hCAFE_0001;
      #2;
      chk("rst_hready_resp", {31'd0, src_hready_resp}, 32'd0);
      chk("rst_hresp", {31'd0, src_hresp}, 32'd1);
      chk("rst_hexokay", {31'd0, src_hexokay}, 32'd0);
      dst_hready_resp = 1'b1;
      dst_hresp       = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // basic success, back-to-back read then write
      issue(8'd0, 32'h100, 1'b0, 1'b1);
      chk("basic_rd_htrans", {30'd0, dst_htrans}, 32'd2);
      tick();
      issue(8'd0, 32'h100, 1'b1, 1'b1);
      chk("basic_wr_htrans", {30'd0, dst_htrans}, 32'd2);
      chk("basic_rd_okay", {31'd0, src_hexokay}, 32'd1);
      chk("basic_rdata", src_hrdata, 32'hCAFE_0001);
      tick();
      idle();
      chk("basic_wr_okay", {31'd0, src_hexokay}, 32'd1);
      chk("basic_wr_ready", {31'd0, src_hready_resp}, 32'd1);
      tick();

      // intervening plain write from another master
      issue(8'd0, 32'h100, 1'b0, 1'b1);
      tick();
      issue(8'd1, 32'h100, 1'b1, 1'b0);
      chk("intv_plain_htrans", {30'd0, dst_htrans}, 32'd2);
      tick();
      issue(8'd0, 32'h100, 1'b1, 1'b1);
      chk("intv_xwr_htrans", {30'd0, dst_htrans}, 32'd0);
      chk("intv_plain_okay", {31'd0, src_hexokay}, 32'd0);
      tick();
      idle();
      dst_hready_resp = 1'b0;
      dst_hresp       = 1'b1;
      #1;
      chk("intv_local_ready", {31'd0, src_hready_resp}, 32'd1);
      chk("intv_local_hresp", {31'd0, src_hresp}, 32'd0);
      chk("intv_local_okay", {31'd0, src_hexokay}, 32'd0);
      tick();
      dst_hready_resp = 1'b1;
      dst_hresp       = 1'b0;
      #1;
      chk("intv_after_local", {31'd0, src_hready_resp}, 32'd1);

      // shared granule
      issue(8'd0, 32'h200, 1'b0, 1'b1);
      tick();
      issue(8'd1, 32'h200, 1'b0, 1'b1);
      tick();
      issue(8'd1, 32'h200, 1'b1, 1'b1);
      chk("shr_m1_htrans", {30'd0, dst_htrans}, 32'd2);
      tick();
      issue(8'd0, 32'h200, 1'b1, 1'b1);
      chk("shr_m1_okay", {31'd0, src_hexokay}, 32'd1);
      chk("shr_m0_htrans", {30'd0, dst_htrans}, 32'd0);
      tick();
      idle();
      chk("shr_m0_okay", {31'd0, src_hexokay}, 32'd0);
      tick();
      issue(8'd0, 32'h200, 1'b0, 1'b1);
      tick();
      issue(8'd1, 32'h204, 1'b1, 1'b0);
      tick();
      issue(8'd0, 32'h200, 1'b1, 1'b1);
      chk("shr_204_keeps_htrans", {30'd0, dst_htrans}, 32'd2);
      tick();
      idle();
      chk("shr_204_keeps_okay", {31'd0, src_hexokay}, 32'd1);
      tick();

      // unmapped master; slot 0 holds the same granule to catch index aliasing
      issue(8'd0, 32'h300, 1'b0, 1'b1);
      tick();
      dst_hrdata = 32'h1234_5678;
      issue(8'd4, 32'h300, 1'b0, 1'b1);
      chk("unm_rd_htrans", {30'd0, dst_htrans}, 32'd2);
      tick();
      chk("unm_rd_okay", {31'd0, src_hexokay}, 32'd0);
      chk("unm_rdata", src_hrdata, 32'h1234_5678);
      issue(8'd4, 32'h300, 1'b1, 1'b1);
      chk("unm_wr_htrans", {30'd0, dst_htrans}, 32'd0);
      tick();
      idle();
      chk("unm_wr_okay", {31'd0, src_hexokay}, 32'd0);
      tick();

      // exclusive read terminated with an error response
      issue(8'd3, 32'h500, 1'b0, 1'b1);
      tick();
      idle();
      dst_hready_resp = 1'b0;
      dst_hresp       = 1'b1;
      #1;
      chk("err_ready_lo", {31'd0, src_hready_resp}, 32'd0);
      chk("err_hresp_1", {31'd0, src_hresp}, 32'd1);
      tick();
      dst_hready_resp = 1'b1;
      #1;
      chk("err_hresp_2", {31'd0, src_hresp}, 32'd1);
      tick();
      dst_hresp = 1'b0;
      issue(8'd3, 32'h500, 1'b1, 1'b1);
      chk("err_xwr_htrans", {30'd0, dst_htrans}, 32'd0);
      tick();
      idle();
      tick();

      // wait states on a forwarded transfer hold the next address phase
      issue(8'd2, 32'h600, 1'b0, 1'b0);
      tick();
      dst_hready_resp = 1'b0;
      issue(8'd2, 32'h700, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("ws_ready_resp", {31'd0, src_hready_resp}, 32'd0);
         chk("ws_dst_hready", {31'd0, dst_hready}, 32'd0);
         tick();
      end
      dst_hready_resp = 1'b1;
      #1;
      chk("ws_release", {31'd0, src_hready_resp}, 32'd1);
      tick();
      issue(8'd2, 32'h700, 1'b1, 1'b1);
      chk("ws_held_xrd_took", {30'd0, dst_htrans}, 32'd2);
      tick();
      idle();
      chk("ws_xwr_okay", {31'd0, src_hexokay}, 32'd1);
      tick();

      // reset mid-operation drops reservations
      issue(8'd2, 32'h400, 1'b0, 1'b1);
      tick();
      idle();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      issue(8'd2, 32'h400, 1'b1, 1'b1);
      chk("rst_xwr_htrans", {30'd0, dst_htrans}, 32'd0);
      tick();
      idle();
      chk("rst_xwr_okay", {31'd0, src_hexokay}, 32'd0);
      chk("rst_xwr_ready", {31'd0, src_hready_resp}, 32'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
